// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : Operand-bypass and load-use interlock unit. Tracks the
//            destination tag {v, addr, rdy} of every instruction in the
//            DEPTH stages after ID. Per read port it selects either the
//            register-file value or the youngest in-flight result. It
//            raises a stall while a needed result is still being produced.
//            Saturating counters record stalled cycles and forwarded reads.
// Ports    : clk, rst (async, active high)     - clock / reset
//            adv, flush                        - pipeline advance / kill
//            iss_vld, iss_wen, iss_addr,
//            iss_rdy                           - ID-stage instruction tag
//            re, ra, rf_data                   - per-port read requests
//            stg_data                          - per-stage current results
//            fwd_data, fwd_sel                 - per-port selected operand
//            stall, stg_busy                   - interlock / tag valid bits
//            stall_cnt, fwd_cnt                - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard #(
    parameter  int XLEN  = 32,
    parameter  int AW    = 5,
    parameter  int DEPTH = 3,
    parameter  int NRD   = 2,
    parameter  int CNT_W = 32,
    localparam int SELW  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    input  logic                  flush,
    input  logic                  iss_vld,
    input  logic                  iss_wen,
    input  logic [AW-1:0]         iss_addr,
    input  logic [SELW-1:0]       iss_rdy,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*AW-1:0]     ra,
    input  logic [NRD*XLEN-1:0]   rf_data,
    input  logic [DEPTH*XLEN-1:0] stg_data,
    output logic [NRD*XLEN-1:0]   fwd_data,
    output logic [NRD*SELW-1:0]   fwd_sel,
    output logic                  stall,
    output logic [DEPTH-1:0]      stg_busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
);

    localparam int              NW      = $clog2(NRD + 1);
    localparam int              CW1     = CNT_W + 1;
    localparam logic [SELW-1:0] RDY_MIN = SELW'(1);
    localparam logic [SELW-1:0] RDY_MAX = SELW'(DEPTH);

    // Tag storage; index 0 is stage 1 (EXE).
    logic [DEPTH-1:0]           tag_v;
    logic [DEPTH-1:0][AW-1:0]   tag_addr;
    logic [DEPTH-1:0][SELW-1:0] tag_rdy;

    logic [NRD-1:0]  hit;
    logic [NRD-1:0]  hazard;
    logic [NW-1:0]   nfwd;
    logic [SELW-1:0] iss_rdy_c;
    logic            iss_tag_v;
    logic [CW1-1:0]  fwd_sum;

    // A result is never ready before stage 1 nor later than the last tracked stage.
    always_comb begin
        iss_rdy_c = iss_rdy;
        if (iss_rdy == '0) begin
            iss_rdy_c = RDY_MIN;
        end else if (iss_rdy > RDY_MAX) begin
            iss_rdy_c = RDY_MAX;
        end
    end

    // Writes to r0 are discarded by the register file, so they are never tracked.
    assign iss_tag_v = iss_vld & iss_wen & (iss_addr != '0);

    // Per-port lookup: the first matching stage (youngest producer) decides.
    // An older producer of the same register is shadowed even when its result
    // is already available.
    always_comb begin
        hit      = '0;
        hazard   = '0;
        nfwd     = '0;
        fwd_sel  = '0;
        fwd_data = rf_data;
        for (int p = 0; p < NRD; p++) begin
            if (re[p] && (ra[p*AW +: AW] != '0)) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!hit[p] && tag_v[k] && (tag_addr[k] == ra[p*AW +: AW])) begin
                        hit[p] = 1'b1;
                        if (SELW'(k + 1) >= tag_rdy[k]) begin
                            fwd_sel[p*SELW +: SELW]  = SELW'(k + 1);
                            fwd_data[p*XLEN +: XLEN] = stg_data[k*XLEN +: XLEN];
                            nfwd                     = nfwd + NW'(1);
                        end else begin
                            hazard[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall    = iss_vld & (|hazard);
    assign stg_busy = tag_v;
    assign fwd_sum  = {1'b0, fwd_cnt} + CW1'(nfwd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v     <= '0;
            tag_addr  <= '0;
            tag_rdy   <= '0;
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (adv) begin
                for (int k = 1; k < DEPTH; k++) begin
                    tag_v[k]    <= tag_v[k-1];
                    tag_addr[k] <= tag_addr[k-1];
                    tag_rdy[k]  <= tag_rdy[k-1];
                end
                // A stalled ID instruction re-issues later; a bubble goes down instead.
                tag_v[0]    <= iss_tag_v & ~stall;
                tag_addr[0] <= iss_addr;
                tag_rdy[0]  <= iss_rdy_c;
            end
            // Kill overrides the shift; later non-blocking write wins.
            if (flush) begin
                tag_v <= '0;
            end

            if (adv && stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (adv && !stall) begin
                if (fwd_sum[CNT_W]) begin
                    fwd_cnt <= '1;
                end else begin
                    fwd_cnt <= fwd_sum[CNT_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_scoreboard
// Purpose  : Self-checking bench for fwd_scoreboard. A queue of in-flight
//            instructions with their age predicts every output each cycle.
//            Directed scenarios pin literal values. A second instance with
//            3-bit counters exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int NRD   = 2;
    localparam int SELW  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  adv, flush, iss_vld, iss_wen;
    logic [AW-1:0]         iss_addr;
    logic [SELW-1:0]       iss_rdy;
    logic [NRD-1:0]        re;
    logic [NRD*AW-1:0]     ra;
    logic [NRD*XLEN-1:0]   rf_data;
    logic [DEPTH*XLEN-1:0] stg_data;

    logic [NRD*XLEN-1:0]   fwd_data, fwd_data3;
    logic [NRD*SELW-1:0]   fwd_sel, fwd_sel3;
    logic                  stall, stall3;
    logic [DEPTH-1:0]      stg_busy, stg_busy3;
    logic [31:0]           stall_cnt, fwd_cnt;
    logic [2:0]            stall_cnt3, fwd_cnt3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .adv(adv), .flush(flush),
        .iss_vld(iss_vld), .iss_wen(iss_wen), .iss_addr(iss_addr), .iss_rdy(iss_rdy),
        .re(re), .ra(ra), .rf_data(rf_data), .stg_data(stg_data),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .stg_busy(stg_busy),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    fwd_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .adv(adv), .flush(flush),
        .iss_vld(iss_vld), .iss_wen(iss_wen), .iss_addr(iss_addr), .iss_rdy(iss_rdy),
        .re(re), .ra(ra), .rf_data(rf_data), .stg_data(stg_data),
        .fwd_data(fwd_data3), .fwd_sel(fwd_sel3), .stall(stall3), .stg_busy(stg_busy3),
        .stall_cnt(stall_cnt3), .fwd_cnt(fwd_cnt3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: list of in-flight writers with their current stage.
    // ------------------------------------------------------------------
    typedef struct {
        int addr;
        int rdy;
        int age;
    } ent_t;

    ent_t   q[$];
    longint m_stall = 0;
    longint m_fwd   = 0;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_eval(output logic [NRD*SELW-1:0] sel,
                                       output logic [NRD*XLEN-1:0] data,
                                       output logic st, output int nf,
                                       output logic [DEPTH-1:0] busy);
        int a, best, brdy;
        sel  = '0;
        data = rf_data;
        st   = 1'b0;
        nf   = 0;
        busy = '0;
        foreach (q[i]) busy[q[i].age-1] = 1'b1;
        for (int p = 0; p < NRD; p++) begin
            a    = int'(ra[p*AW +: AW]);
            best = 0;
            brdy = 0;
            if (re[p] && a != 0) begin
                foreach (q[i]) begin
                    if (q[i].addr == a && (best == 0 || q[i].age < best)) begin
                        best = q[i].age;
                        brdy = q[i].rdy;
                    end
                end
            end
            if (best != 0) begin
                if (best >= brdy) begin
                    sel[p*SELW +: SELW]  = SELW'(best);
                    data[p*XLEN +: XLEN] = stg_data[(best-1)*XLEN +: XLEN];
                    nf++;
                end else if (iss_vld) begin
                    st = 1'b1;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model_update
        logic [NRD*SELW-1:0] s;
        logic [NRD*XLEN-1:0] d;
        logic                st;
        int                  nf, r;
        logic [DEPTH-1:0]    b;
        ent_t                nq[$];
        ent_t                e;
        if (rst) begin
            q.delete();
            m_stall = 0;
            m_fwd   = 0;
        end else begin
            model_eval(s, d, st, nf, b);
            if (adv && st)  m_stall++;
            if (adv && !st) m_fwd += nf;
            if (adv) begin
                nq.delete();
                foreach (q[i]) begin
                    e = q[i];
                    e.age++;
                    if (e.age <= DEPTH) nq.push_back(e);
                end
                if (iss_vld && iss_wen && iss_addr != 0 && !st) begin
                    r = int'(iss_rdy);
                    if (r == 0) r = 1;
                    if (r > DEPTH) r = DEPTH;
                    e.addr = int'(iss_addr);
                    e.rdy  = r;
                    e.age  = 1;
                    nq.push_back(e);
                end
                q = nq;
            end
            if (flush) q.delete();
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin : compare
        logic [NRD*SELW-1:0] es;
        logic [NRD*XLEN-1:0] ed;
        logic                est;
        int                  enf;
        logic [DEPTH-1:0]    eb;
        model_eval(es, ed, est, enf, eb);
        chk("m_fwd_sel",   64'(fwd_sel),   64'(es));
        chk("m_fwd_data",  64'(fwd_data),  64'(ed));
        chk("m_stall",     64'(stall),     64'(est));
        chk("m_stg_busy",  64'(stg_busy),  64'(eb));
        chk("m_stall_cnt", 64'(stall_cnt), 64'(sat(m_stall, 32)));
        chk("m_fwd_cnt",   64'(fwd_cnt),   64'(sat(m_fwd, 32)));
        chk("m_stall3",    64'(stall3),    64'(est));
        chk("m_stall_cnt3", 64'(stall_cnt3), 64'(sat(m_stall, 3)));
        chk("m_fwd_cnt3",  64'(fwd_cnt3),  64'(sat(m_fwd, 3)));
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        adv      = 1'b1;
        flush    = 1'b0;
        iss_vld  = 1'b0;
        iss_wen  = 1'b0;
        iss_addr = '0;
        iss_rdy  = '0;
        re       = '0;
        ra       = '0;
    endtask

    task automatic issue(input int addr, input int rdy);
        iss_vld  = 1'b1;
        iss_wen  = 1'b1;
        iss_addr = AW'(addr);
        iss_rdy  = SELW'(rdy);
    endtask

    initial begin
        rst      = 1'b1;
        idle();
        rf_data  = {32'h0000_BBBB, 32'h0000_AAAA};
        stg_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        // Reset state
        @(negedge clk);
        chk("rst_busy",  64'(stg_busy),  64'h0);
        chk("rst_stall", 64'(stall),     64'h0);
        chk("rst_sel",   64'(fwd_sel),   64'h0);
        chk("rst_data",  64'(fwd_data),  64'h0000_BBBB_0000_AAAA);
        chk("rst_scnt",  64'(stall_cnt), 64'h0);
        chk("rst_fcnt",  64'(fwd_cnt),   64'h0);
        #2 rst = 1'b0;
        next_cycle();

        // ALU chain: r3 ready in stage 1, read next cycle
        issue(3, 1);
        next_cycle();
        idle();
        iss_vld = 1'b1;
        re      = 2'b01;
        ra      = {5'd0, 5'd3};
        stg_data[31:0] = 32'h1234;
        @(negedge clk);
        chk("alu_sel",   64'(fwd_sel),        64'h1);
        chk("alu_data",  64'(fwd_data[31:0]), 64'h1234);
        chk("alu_stall", 64'(stall),          64'h0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("alu_fcnt",  64'(fwd_cnt),        64'h1);

        // Load-use: r5 ready in stage 2, read back-to-back
        next_cycle();
        flush = 1'b1;
        next_cycle();
        idle();
        issue(5, 2);
        next_cycle();
        idle();
        issue(6, 1);
        re = 2'b01;
        ra = {5'd0, 5'd5};
        stg_data[63:32] = 32'hCAFE;
        @(negedge clk);
        chk("lu_stall1", 64'(stall),   64'h1);
        chk("lu_sel1",   64'(fwd_sel), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("lu_stall2", 64'(stall),           64'h0);
        chk("lu_sel2",   64'(fwd_sel),         64'h2);
        chk("lu_data",   64'(fwd_data[31:0]),  64'hCAFE);
        chk("lu_busy",   64'(stg_busy),        64'b010);
        chk("lu_scnt",   64'(stall_cnt),       64'h1);
        next_cycle();

        // Youngest wins: r7 in stages 1 and 2
        idle();
        issue(7, 1);
        next_cycle();
        issue(7, 1);
        next_cycle();
        idle();
        iss_vld  = 1'b1;
        re       = 2'b11;
        ra       = {5'd7, 5'd7};
        stg_data = {32'h0, 32'h22, 32'h11};
        @(negedge clk);
        chk("yw_sel",  64'(fwd_sel),  64'b0101);
        chk("yw_data", 64'(fwd_data), 64'h0000_0011_0000_0011);

        // r0 is never tracked; re=0 never stalls
        next_cycle();
        idle();
        issue(0, 1);
        next_cycle();
        idle();
        re = 2'b01;
        ra = {5'd0, 5'd0};
        @(negedge clk);
        chk("r0_sel",  64'(fwd_sel),     64'h0);
        chk("r0_data", 64'(fwd_data),    64'h0000_BBBB_0000_AAAA);
        chk("r0_busy", 64'(stg_busy[0]), 64'h0);
        next_cycle();
        issue(9, 3);
        next_cycle();
        idle();
        iss_vld = 1'b1;
        ra      = {5'd9, 5'd9};
        @(negedge clk);
        chk("re0_stall", 64'(stall), 64'h0);

        // Freeze with a pending load, then flush while frozen
        next_cycle();
        idle();
        flush = 1'b1;
        next_cycle();
        idle();
        issue(4, 2);
        next_cycle();
        idle();
        iss_vld = 1'b1;
        re      = 2'b01;
        ra      = {5'd0, 5'd4};
        adv     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fz_stall", 64'(stall),     64'h1);
            chk("fz_busy",  64'(stg_busy),  64'b001);
            chk("fz_scnt",  64'(stall_cnt), 64'h1);
            next_cycle();
        end
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_busy",  64'(stg_busy),  64'h0);
        chk("fl_stall", 64'(stall),     64'h0);
        chk("fl_scnt",  64'(stall_cnt), 64'h1);

        // Saturation: five rdy=3 loads read back-to-back, 2 stalls each
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            idle();
            issue(8, 3);
            next_cycle();
            idle();
            iss_vld = 1'b1;
            re      = 2'b01;
            ra      = {5'd0, 5'd8};
            next_cycle();
            next_cycle();
        end
        @(negedge clk);
        chk("sat_scnt",  64'(stall_cnt),  64'd11);
        chk("sat_scnt3", 64'(stall_cnt3), 64'd7);

        // Asynchronous reset in the middle of a stall
        next_cycle();
        idle();
        issue(8, 3);
        next_cycle();
        idle();
        iss_vld = 1'b1;
        re      = 2'b01;
        ra      = {5'd0, 5'd8};
        @(negedge clk);
        chk("ar_pre", 64'(stall), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("ar_stall", 64'(stall),      64'h0);
        chk("ar_busy",  64'(stg_busy),   64'h0);
        chk("ar_scnt",  64'(stall_cnt),  64'h0);
        chk("ar_fcnt",  64'(fwd_cnt),    64'h0);
        chk("ar_scnt3", 64'(stall_cnt3), 64'h0);
        chk("ar_sel",   64'(fwd_sel),    64'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ar_after", 64'(stall), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            adv      = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            iss_vld  = ($urandom_range(0, 4) != 0);
            iss_wen  = ($urandom_range(0, 9) < 7);
            iss_addr = AW'($urandom_range(0, 7));
            iss_rdy  = SELW'($urandom_range(0, 3));
            re       = NRD'($urandom_range(0, 3));
            ra       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            rf_data  = {$urandom, $urandom};
            stg_data = {$urandom, $urandom, $urandom};
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
